ahb3lite_wbuf: RTL and testbench
================================

Name: ahb3lite_wbuf

Overview:
Posted-write buffer that sits directly upstream of the AHB-Lite-to-APB bridge, on the HCLK side. It acknowledges AHB-Lite writes with zero wait states, queues them, and replays each one to the bridge as a single NONSEQ transfer. Reads drain the queue first, then pass through, which keeps write-to-read ordering.

Parameters:
HADDR_SIZE, 32, address width on both ports
HDATA_SIZE, 32, data width on both ports
DEPTH, 4, number of posted-write entries (power of 2, minimum 2)

Ports:
HRESETn  in  1  asynchronous, active-low reset
HCLK  in  1  clock for both ports
HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY  in  std AHB-Lite widths  upstream slave inputs
HRDATA  out  HDATA_SIZE  upstream read data
HREADYOUT  out  1  upstream ready
HRESP  out  1  upstream response
M_HSEL  out  1  downstream select
M_HADDR  out  HADDR_SIZE  downstream address
M_HWDATA  out  HDATA_SIZE  downstream write data
M_HWRITE  out  1  downstream direction
M_HSIZE  out  3  downstream size
M_HBURST  out  3  downstream burst, always SINGLE
M_HPROT  out  4  downstream protection
M_HTRANS  out  2  downstream transfer type
M_HMASTLOCK  out  1  downstream lock, tied 0
M_HRDATA  in  HDATA_SIZE  downstream read data
M_HREADYOUT  in  1  downstream ready; also fed back externally as the bridge's HREADY
M_HRESP  in  1  downstream response
wbuf_empty  out  1  queue empty and downstream idle
wbuf_err  out  1  sticky: a posted write received an ERROR response
wbuf_err_addr  out  HADDR_SIZE  address of the first failed posted write
err_clr  in  1  clears wbuf_err

Behaviour:
- Reset values:
  - HREADYOUT=1, HRESP=OKAY, HRDATA=0.
  - All M_* outputs 0 (M_HTRANS=IDLE).
  - wbuf_empty=1, wbuf_err=0, wbuf_err_addr=0.
  - FIFO pointers and count cleared.
  - Reset mid-operation discards all queued writes; the bridge must be reset in the same domain event.
- Transfer qualification: an upstream address phase is valid when HSEL & HREADY & HTRANS∈{NONSEQ,SEQ}. IDLE and BUSY transfers get a zero-wait OKAY.
- Upstream FSM, states S_IDLE, S_WDATA, S_RWAIT, S_ERR:
  - Valid write: latch HADDR/HSIZE/HPROT and go to S_WDATA.
  - S_WDATA, FIFO not full: push {addr,size,prot,HWDATA} that cycle; HREADYOUT=1 (zero wait). Back-to-back writes are accepted every cycle.
  - S_WDATA, FIFO full: HREADYOUT=0 until a pop frees a slot. A pop and a push in the same cycle while full is legal; the count is unchanged.
  - Valid read: go to S_RWAIT with HREADYOUT=0.
  - S_RWAIT stays until the FIFO is empty and the downstream FSM is idle. It then requests a downstream read.
  - Read completing OKAY: HRDATA=M_HRDATA, HREADYOUT=1, back to S_IDLE.
  - Read completing ERROR: cycle 1 HRESP=ERROR, HREADYOUT=0; cycle 2 (S_ERR) HRESP=ERROR, HREADYOUT=1.
  - Read latency = drain time + 1 address cycle + downstream wait cycles + 1.
- Downstream FSM, states M_IDLE, M_ADDR, M_DATA:
  - Issue only when M_HREADYOUT=1.
  - M_ADDR: M_HSEL=1, M_HTRANS=NONSEQ, FIFO head (or the pending read) presented for exactly one cycle.
  - M_DATA: M_HTRANS=IDLE, M_HSEL=0, M_HWDATA=head data held stable; completes on M_HREADYOUT=1.
  - There is no address/data pipelining downstream: at least one idle cycle between transfers.
  - Pending read priority applies only once the FIFO is empty; writes always drain in order first.
  - Pop the head on write completion, whether OKAY or ERROR.
  - A write ERROR sets wbuf_err. It loads wbuf_err_addr only if wbuf_err was 0.
  - err_clr and a new error in the same cycle: the error wins (wbuf_err stays 1, address reloaded).
- wbuf_empty = (count==0) & downstream FSM in M_IDLE.
- Widths: count is clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Decomposition:
- Reuse ahb3lite_pkg for HTRANS_*, HRESP_*, HBURST_SINGLE and the HSIZE constants.
- FSM enums stay local to the block.
- One sub-module, wbuf_fifo: synchronous FIFO with parameterised width and DEPTH, push/pop/full/empty/count, and a registered head output.

Test Plan:
- Write 0x40←0xA5A5A5A5 with downstream ready → HREADYOUT stays 1; M_HADDR=0x40 NONSEQ one cycle later; M_HWDATA=0xA5A5A5A5 in the next cycle; wbuf_empty returns to 1.
- 5 back-to-back writes, DEPTH=4, downstream holding M_HREADYOUT=0 for 10 cycles per beat → first 4 writes are zero-wait, 5th data phase stalls until the first pop; downstream order 0x0,0x4,0x8,0xC,0x10.
- Write 0x20←0x11 then read 0x20 → read stalls until the write completes downstream; HRDATA equals M_HRDATA; downstream shows write before read.
- Posted write to 0x80 answered ERROR → upstream saw OKAY; wbuf_err=1, wbuf_err_addr=0x80. A second error at 0x84 leaves the address at 0x80. err_clr clears wbuf_err.
- Read answered ERROR downstream → upstream sees 2-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both cycles).
- HRESETn asserted with 3 queued writes → all outputs at reset values immediately; no further downstream transfers after release.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB-Lite transfer, response, burst and size encodings
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: synchronous FIFO with a registered head entry
module wbuf_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          HRESETn,
  input  logic          HCLK,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  assign rd_nxt = rd_ptr + AW'(pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge HCLK)
    if (push) mem[wr_ptr] <= din;
  // head tracks the entry at the post-pop read pointer, bypassing a same-cycle write into it
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      head <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_nxt;
      count <= count + CW'(push) - CW'(pop);
      head <= (push && wr_ptr == rd_nxt) ? din : mem[rd_nxt];
    end
endmodule

// File: rtl/ahb3lite_wbuf.sv
// ahb3lite_wbuf: posted-write buffer in front of an AHB-Lite-to-APB bridge; reads drain the queue first
module ahb3lite_wbuf
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int DEPTH = 4
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  M_HSEL,
  output logic [HADDR_SIZE-1:0] M_HADDR,
  output logic [HDATA_SIZE-1:0] M_HWDATA,
  output logic                  M_HWRITE,
  output logic [2:0]            M_HSIZE,
  output logic [2:0]            M_HBURST,
  output logic [3:0]            M_HPROT,
  output logic [1:0]            M_HTRANS,
  output logic                  M_HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] M_HRDATA,
  input  logic                  M_HREADYOUT,
  input  logic                  M_HRESP,
  output logic                  wbuf_empty,
  output logic                  wbuf_err,
  output logic [HADDR_SIZE-1:0] wbuf_err_addr,
  input  logic                  err_clr
);
  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RWAIT, S_ERR} u_state_t;
  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} m_state_t;
  localparam int EW = HADDR_SIZE + 7 + HDATA_SIZE;
  u_state_t u_state, u_nxt;
  m_state_t m_state, m_nxt;
  logic [HADDR_SIZE-1:0] a_addr, h_addr;
  logic [2:0] a_size, h_size;
  logic [3:0] a_prot, h_prot;
  logic [HDATA_SIZE-1:0] h_data;
  logic [EW-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic valid, push, pop, full, empty, rd_done, rd_err, m_rd, m_addr_ph, m_wdata_ph;
  logic unused;
  assign unused = ^{HBURST, HMASTLOCK};
  assign valid = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign pop = m_state == M_DATA && !m_rd && M_HREADYOUT;
  assign rd_done = m_state == M_DATA && m_rd && M_HREADYOUT;
  assign rd_err = u_state == S_RWAIT && rd_done && M_HRESP;
  // a pop in the same cycle frees the slot, so a full queue still accepts the write
  assign push = u_state == S_WDATA && (!full || pop);
  assign {h_addr, h_size, h_prot, h_data} = head;
  wbuf_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .HRESETn(HRESETn),
    .HCLK(HCLK),
    .push(push),
    .pop(pop),
    .din({a_addr, a_size, a_prot, HWDATA}),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign HREADYOUT = u_state == S_WDATA ? push :
                     u_state == S_RWAIT ? rd_done && !M_HRESP : 1'b1;
  assign HRESP = (rd_err || u_state == S_ERR) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = (u_state == S_RWAIT && rd_done && !M_HRESP) ? M_HRDATA : '0;
  always_comb
    u_nxt = rd_err ? S_ERR :
            !HREADYOUT ? u_state :
            valid ? (HWRITE ? S_WDATA : S_RWAIT) : S_IDLE;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) u_state <= S_IDLE;
    else u_state <= u_nxt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      a_addr <= '0;
      a_size <= '0;
      a_prot <= '0;
    end else if (HREADYOUT && valid) begin
      a_addr <= HADDR;
      a_size <= HSIZE;
      a_prot <= HPROT;
    end
  // queued writes always go first; the pending read is issued only once the queue is empty
  always_comb
    m_nxt = m_state == M_IDLE ? ((M_HREADYOUT && (!empty || u_state == S_RWAIT)) ? M_ADDR : M_IDLE) :
            m_state == M_ADDR ? M_DATA :
            M_HREADYOUT ? M_IDLE : M_DATA;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      m_state <= M_IDLE;
      m_rd <= 1'b0;
    end else begin
      m_state <= m_nxt;
      if (m_state == M_IDLE && m_nxt == M_ADDR) m_rd <= empty;
    end
  assign m_addr_ph = m_state == M_ADDR;
  assign m_wdata_ph = m_state == M_DATA && !m_rd;
  assign M_HSEL = m_addr_ph;
  assign M_HADDR = m_addr_ph ? (m_rd ? a_addr : h_addr) : '0;
  assign M_HWRITE = m_addr_ph && !m_rd;
  assign M_HSIZE = m_addr_ph ? (m_rd ? a_size : h_size) : '0;
  assign M_HPROT = m_addr_ph ? (m_rd ? a_prot : h_prot) : '0;
  assign M_HTRANS = m_addr_ph ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign M_HBURST = HBURST_SINGLE;
  assign M_HMASTLOCK = 1'b0;
  assign M_HWDATA = m_wdata_ph ? h_data : '0;
  assign wbuf_empty = count == '0 && m_state == M_IDLE;
  // a new write error wins over err_clr and reloads the captured address
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wbuf_err <= 1'b0;
      wbuf_err_addr <= '0;
    end else if (pop && M_HRESP) begin
      wbuf_err <= 1'b1;
      if (!wbuf_err || err_clr) wbuf_err_addr <= h_addr;
    end else if (err_clr) begin
      wbuf_err <= 1'b0;
    end
endmodule

// File: tb/tb_ahb3lite_wbuf.sv
// tb_ahb3lite_wbuf: scoreboard bench for the posted-write buffer with a modelled downstream bridge
module tb_ahb3lite_wbuf;
  import ahb3lite_pkg::*;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic M_HSEL, M_HWRITE, M_HMASTLOCK, M_HREADYOUT, M_HRESP;
  logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
  logic [2:0] M_HSIZE, M_HBURST;
  logic [3:0] M_HPROT;
  logic [1:0] M_HTRANS;
  logic wbuf_empty, wbuf_err, err_clr;
  logic [31:0] wbuf_err_addr;
  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;
  ahb3lite_wbuf #(.HADDR_SIZE(32), .HDATA_SIZE(32), .DEPTH(4)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA),
    .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HPROT(M_HPROT),
    .M_HTRANS(M_HTRANS), .M_HMASTLOCK(M_HMASTLOCK), .M_HRDATA(M_HRDATA),
    .M_HREADYOUT(M_HREADYOUT), .M_HRESP(M_HRESP), .wbuf_empty(wbuf_empty),
    .wbuf_err(wbuf_err), .wbuf_err_addr(wbuf_err_addr), .err_clr(err_clr)
  );
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] data;} xfer_t;
  xfer_t sb[$];
  int checks = 0, errors = 0, xfers = 0, dly = 0, rd_wait = 0;
  logic [31:0] wa[8], wd[8];
  int stl[8];
  logic [31:0] mon_a, mon_d;
  logic mon_w, mon_bad;
  xfer_t mon_e;
  function automatic logic [31:0] rd_model(logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic is_bad(logic [31:0] a);
    return a == 32'h80 || a == 32'h84 || a == 32'h300;
  endfunction
  // downstream bridge model: dly wait cycles per data phase, two-cycle ERROR on bad addresses
  initial begin
    M_HREADYOUT = 1'b1; M_HRESP = 1'b0; M_HRDATA = '0;
    forever begin
      @(posedge HCLK); #1;
      M_HREADYOUT = 1'b1; M_HRESP = 1'b0; M_HRDATA = '0;
      if (HRESETn && M_HSEL && M_HTRANS == HTRANS_NONSEQ) begin
        mon_a = M_HADDR; mon_w = M_HWRITE; mon_bad = is_bad(mon_a); mon_d = 'x;
        xfers++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL order: unexpected downstream transfer addr %h wr %b, expected none", mon_a, mon_w);
        end else begin
          mon_e = sb.pop_front();
          mon_d = mon_e.data;
          if (mon_e.addr !== mon_a || mon_e.wr !== mon_w) begin
            errors++;
            $display("FAIL order: downstream addr %h wr %b, expected addr %h wr %b", mon_a, mon_w, mon_e.addr, mon_e.wr);
          end
        end
        @(posedge HCLK); #1;
        for (int i = 0; i < dly && HRESETn; i++) begin
          M_HREADYOUT = 1'b0;
          @(posedge HCLK); #1;
        end
        if (HRESETn && mon_bad) begin
          M_HREADYOUT = 1'b0; M_HRESP = 1'b1;
          @(posedge HCLK); #1;
        end
        M_HREADYOUT = 1'b1;
        M_HRESP = HRESETn && mon_bad;
        M_HRDATA = (HRESETn && !mon_w) ? rd_model(mon_a) : '0;
        if (HRESETn && mon_w) begin
          checks++;
          if (M_HWDATA !== mon_d) begin
            errors++;
            $display("FAIL wdata: M_HWDATA %h at addr %h, expected %h", M_HWDATA, mon_a, mon_d);
          end
        end
      end
    end
  end
  task automatic wait_rdy(input string nm, output int n);
    n = 0;
    @(negedge HCLK);
    while (!HREADYOUT && n < 300) begin
      n++;
      @(negedge HCLK);
    end
    if (!HREADYOUT) begin
      checks++; errors++;
      $display("FAIL %s timeout: HREADYOUT 0 after %0d cycles, expected 1", nm, n);
    end
  endtask
  task automatic wait_empty(input string nm);
    int n = 0;
    @(negedge HCLK);
    while (!wbuf_empty && n < 1000) begin
      n++;
      @(negedge HCLK);
    end
    checks++;
    if (!wbuf_empty) begin
      errors++;
      $display("FAIL %s: wbuf_empty %b after %0d cycles, expected 1", nm, wbuf_empty, n);
    end
    @(posedge HCLK); #1;
  endtask
  task automatic ahb_writes(input int n);
    xfer_t t;
    int k;
    HSEL = 1'b1; HWRITE = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = wa[0];
    t.addr = wa[0]; t.wr = 1'b1; t.data = wd[0];
    sb.push_back(t);
    wait_rdy("waddr", k);
    @(posedge HCLK); #1;
    for (int i = 0; i < n; i++) begin
      HWDATA = wd[i];
      if (i + 1 < n) begin
        HADDR = wa[i+1];
        t.addr = wa[i+1]; t.data = wd[i+1];
        sb.push_back(t);
      end else begin
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE;
      end
      wait_rdy("wdata", stl[i]);
      checks++;
      if (HRESP !== HRESP_OKAY) begin
        errors++;
        $display("FAIL wresp: write %0d HRESP %b, expected 0", i, HRESP);
      end
      @(posedge HCLK); #1;
    end
  endtask
  task automatic ahb_read(input logic [31:0] a, input logic exp_err, input string nm);
    xfer_t t;
    int n;
    HSEL = 1'b1; HWRITE = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = a;
    t.addr = a; t.wr = 1'b0; t.data = '0;
    sb.push_back(t);
    wait_rdy(nm, n);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    n = 0;
    @(negedge HCLK);
    while (!HREADYOUT && !HRESP && n < 300) begin
      n++;
      @(negedge HCLK);
    end
    rd_wait = n;
    checks++;
    if (exp_err) begin
      if (HRESP !== 1'b1 || HREADYOUT !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle1: HRESP %b HREADYOUT %b, expected 1 0", nm, HRESP, HREADYOUT);
      end
      @(negedge HCLK);
      checks++;
      if (HRESP !== 1'b1 || HREADYOUT !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle2: HRESP %b HREADYOUT %b, expected 1 1", nm, HRESP, HREADYOUT);
      end
    end else if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== rd_model(a)) begin
      errors++;
      $display("FAIL %s: HREADYOUT %b HRESP %b HRDATA %h, expected 1 0 %h", nm, HREADYOUT, HRESP, HRDATA, rd_model(a));
    end
    @(posedge HCLK); #1;
  endtask
  task automatic test_reset();
    HSEL = 0; HADDR = 0; HWDATA = 0; HWRITE = 0; HSIZE = HSIZE_WORD; HBURST = HBURST_SINGLE;
    HPROT = 4'h3; HTRANS = HTRANS_IDLE; HMASTLOCK = 0; err_clr = 0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    checks += 4;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== '0) begin
      errors++;
      $display("FAIL reset_up: HREADYOUT %b HRESP %b HRDATA %h, expected 1 0 0", HREADYOUT, HRESP, HRDATA);
    end
    if (M_HSEL !== 1'b0 || M_HTRANS !== HTRANS_IDLE || M_HADDR !== '0 || M_HWRITE !== 1'b0) begin
      errors++;
      $display("FAIL reset_dn: M_HSEL %b M_HTRANS %b M_HADDR %h M_HWRITE %b, expected 0 0 0 0", M_HSEL, M_HTRANS, M_HADDR, M_HWRITE);
    end
    if (M_HWDATA !== '0 || M_HMASTLOCK !== 1'b0 || M_HBURST !== 3'b000) begin
      errors++;
      $display("FAIL reset_dn2: M_HWDATA %h M_HMASTLOCK %b M_HBURST %b, expected 0 0 0", M_HWDATA, M_HMASTLOCK, M_HBURST);
    end
    if (wbuf_empty !== 1'b1 || wbuf_err !== 1'b0 || wbuf_err_addr !== '0) begin
      errors++;
      $display("FAIL reset_status: empty %b err %b err_addr %h, expected 1 0 0", wbuf_empty, wbuf_err, wbuf_err_addr);
    end
    @(posedge HCLK); #1;
  endtask
  task automatic test_single_write();
    dly = 0;
    wa[0] = 32'h40; wd[0] = 32'hA5A5_A5A5;
    ahb_writes(1);
    checks += 2;
    if (stl[0] != 0) begin
      errors++;
      $display("FAIL single_stall: %0d wait states, expected 0", stl[0]);
    end
    if (wbuf_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_queued: wbuf_empty %b, expected 0", wbuf_empty);
    end
    wait_empty("single_drain");
  endtask
  task automatic test_back_to_back();
    dly = 10;
    for (int i = 0; i < 5; i++) begin
      wa[i] = 32'(i * 4);
      wd[i] = $urandom;
    end
    ahb_writes(5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stl[i] != 0) begin
        errors++;
        $display("FAIL b2b_stall%0d: %0d wait states, expected 0", i, stl[i]);
      end
    end
    checks++;
    if (stl[4] == 0) begin
      errors++;
      $display("FAIL b2b_full: 5th write %0d wait states, expected >0", stl[4]);
    end
    wait_empty("b2b_drain");
  endtask
  task automatic test_write_read();
    dly = 2;
    wa[0] = 32'h20; wd[0] = 32'h11;
    ahb_writes(1);
    ahb_read(32'h20, 1'b0, "wr_rd");
    checks++;
    if (rd_wait == 0) begin
      errors++;
      $display("FAIL wr_rd_stall: read stalled %0d cycles, expected >0", rd_wait);
    end
    wait_empty("wr_rd_drain");
  endtask
  task automatic test_write_error();
    dly = 0;
    wa[0] = 32'h80; wd[0] = 32'h1;
    ahb_writes(1);
    wait_empty("werr1_drain");
    checks++;
    if (wbuf_err !== 1'b1 || wbuf_err_addr !== 32'h80) begin
      errors++;
      $display("FAIL werr1: err %b addr %h, expected 1 00000080", wbuf_err, wbuf_err_addr);
    end
    wa[0] = 32'h84; wd[0] = 32'h2;
    ahb_writes(1);
    wait_empty("werr2_drain");
    checks++;
    if (wbuf_err !== 1'b1 || wbuf_err_addr !== 32'h80) begin
      errors++;
      $display("FAIL werr2: err %b addr %h, expected 1 00000080", wbuf_err, wbuf_err_addr);
    end
    err_clr = 1'b1;
    @(posedge HCLK); #1;
    err_clr = 1'b0;
    checks++;
    if (wbuf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: err %b, expected 0", wbuf_err);
    end
  endtask
  task automatic test_read_error();
    dly = 1;
    ahb_read(32'h300, 1'b1, "rd_err");
    wait_empty("rd_err_drain");
  endtask
  task automatic test_async_reset();
    int base;
    dly = 20;
    for (int i = 0; i < 3; i++) begin
      wa[i] = 32'h100 + 32'(i * 4);
      wd[i] = 32'hC0DE_0000 + 32'(i);
    end
    ahb_writes(3);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    checks += 2;
    if (HREADYOUT !== 1'b1 || M_HSEL !== 1'b0 || M_HTRANS !== HTRANS_IDLE || M_HADDR !== '0 || M_HWDATA !== '0) begin
      errors++;
      $display("FAIL areset_out: HREADYOUT %b M_HSEL %b M_HTRANS %b M_HADDR %h M_HWDATA %h, expected 1 0 0 0 0",
               HREADYOUT, M_HSEL, M_HTRANS, M_HADDR, M_HWDATA);
    end
    if (wbuf_empty !== 1'b1 || wbuf_err_addr !== '0) begin
      errors++;
      $display("FAIL areset_status: empty %b err_addr %h, expected 1 0", wbuf_empty, wbuf_err_addr);
    end
    sb.delete();
    base = xfers;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    repeat (60) @(posedge HCLK);
    #1;
    checks += 2;
    if (xfers != base) begin
      errors++;
      $display("FAIL areset_discard: %0d downstream transfers after reset, expected 0", xfers - base);
    end
    if (wbuf_empty !== 1'b1) begin
      errors++;
      $display("FAIL areset_empty: wbuf_empty %b, expected 1", wbuf_empty);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_read();
    test_write_error();
    test_read_error();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left: %0d expected transfers never seen, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
